// File: rtl/vim_scan_pkg.sv
// vim_scan_pkg
// Shared types and defaults for the scan-protection unlock path.
//   scan_ldr_state_t        : key loader state encoding
//   SCAN_IDLE_WORD          : value driven on scan_key when no word is presented
//   SCAN_LDR_MAX_WORDS      : default word budget before permanent lockout
//   SCAN_LDR_TIMEOUT_CYCLES : default idle cycles allowed inside a partial word

`ifndef SCAN_KEY_WIDTH
`define SCAN_KEY_WIDTH 32
`endif

`ifndef SCAN_KEY_NUMBER
`define SCAN_KEY_NUMBER 8
`endif

package vim_scan_pkg;

    typedef enum logic [2:0] {
        SCAN_LDR_IDLE   = 3'd0,
        SCAN_LDR_SHIFT  = 3'd1,
        SCAN_LDR_ISSUE  = 3'd2,
        SCAN_LDR_DONE   = 3'd3,
        SCAN_LDR_LOCKED = 3'd4
    } scan_ldr_state_t;

    localparam logic [`SCAN_KEY_WIDTH-1:0] SCAN_IDLE_WORD = '0;

    localparam int SCAN_LDR_MAX_WORDS      = 16;
    localparam int SCAN_LDR_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/vim_scan_key_loader.sv
// vim_scan_key_loader
// Deserializes an MSB-first key bitstream into SCAN_KEY_WIDTH-bit words and
// presents each completed word to vim_scan_control for exactly one cycle.
// A word budget and an inter-bit timeout bound the number of unlock attempts.
//
// Ports:
//   clk             : clock, all state on rising edge
//   rst_n           : asynchronous active-low reset
//   key_sdi         : serial key data, MSB first
//   key_sdi_valid   : key_sdi sampled when high
//   key_sof         : start of word, qualified by key_sdi_valid
//   scan_unlock     : unlock status from vim_scan_control
//   scan_key        : assembled word, SCAN_IDLE_WORD when idle
//   key_word_issued : one-cycle pulse with each presented word
//   key_frame_err   : one-cycle pulse when a partial word times out
//   loader_locked   : sticky lockout indicator
//   words_issued    : saturating count of issued words
//
// state  | meaning
// IDLE   | no partial word held, bit count 0
// SHIFT  | partial word held, timeout running
// ISSUE  | completed word on scan_key for this single cycle
// DONE   | unlocked; input ignored, outputs frozen
// LOCKED | word budget exhausted; input ignored until reset

`ifndef SCAN_KEY_WIDTH
`define SCAN_KEY_WIDTH 32
`endif

`ifndef SCAN_KEY_NUMBER
`define SCAN_KEY_NUMBER 8
`endif

module vim_scan_key_loader
    import vim_scan_pkg::*;
#(
    parameter int SCAN_KEY_WIDTH  = `SCAN_KEY_WIDTH,
    parameter int SCAN_KEY_NUMBER = `SCAN_KEY_NUMBER,
    parameter int MAX_WORDS       = SCAN_LDR_MAX_WORDS,
    parameter int TIMEOUT_CYCLES  = SCAN_LDR_TIMEOUT_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             key_sdi,
    input  logic                             key_sdi_valid,
    input  logic                             key_sof,
    input  logic                             scan_unlock,
    output logic [SCAN_KEY_WIDTH-1:0]        scan_key,
    output logic                             key_word_issued,
    output logic                             key_frame_err,
    output logic                             loader_locked,
    output logic [$clog2(MAX_WORDS+1)-1:0]   words_issued
);

    localparam int WCW = $clog2(MAX_WORDS + 1);
    localparam int BCW = $clog2(SCAN_KEY_WIDTH + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WCW-1:0] WORDS_MAX = WCW'(MAX_WORDS);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(SCAN_KEY_WIDTH);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

    // A budget smaller than one full sequence plus one would lock out a
    // legitimate unlock attempt.
    if (MAX_WORDS < SCAN_KEY_NUMBER + 1) begin : g_budget_check
        $error("MAX_WORDS must be at least SCAN_KEY_NUMBER+1");
    end

    if (SCAN_KEY_WIDTH < 2) begin : g_width_check
        $error("SCAN_KEY_WIDTH must be at least 2");
    end

    scan_ldr_state_t            state_q, state_d;
    logic [SCAN_KEY_WIDTH-1:0]  shreg_q, shreg_d;
    logic [BCW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [TCW-1:0]             to_cnt_q, to_cnt_d;
    logic [SCAN_KEY_WIDTH-1:0]  scan_key_q, scan_key_d;
    logic                       issued_q, issued_d;
    logic                       ferr_q, ferr_d;
    logic                       locked_q, locked_d;
    logic [WCW-1:0]             words_q, words_d;

    logic [SCAN_KEY_WIDTH-1:0]  shift_word;
    logic [BCW-1:0]             bit_cnt_inc;
    logic                       word_done;

    // key_sof restarts the word with the current bit as its first bit.
    assign shift_word  = key_sof ? {{(SCAN_KEY_WIDTH-1){1'b0}}, key_sdi}
                                 : {shreg_q[SCAN_KEY_WIDTH-2:0], key_sdi};
    assign bit_cnt_inc = key_sof ? BCW'(1) : bit_cnt_q + BCW'(1);
    assign word_done   = (bit_cnt_inc == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCAN_LDR_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            scan_key_q <= '0;
            issued_q   <= 1'b0;
            ferr_q     <= 1'b0;
            locked_q   <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            to_cnt_q   <= to_cnt_d;
            scan_key_q <= scan_key_d;
            issued_q   <= issued_d;
            ferr_q     <= ferr_d;
            locked_q   <= locked_d;
            words_q    <= words_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        to_cnt_d   = '0;
        scan_key_d = SCAN_KEY_WIDTH'(SCAN_IDLE_WORD);
        issued_d   = 1'b0;
        ferr_d     = 1'b0;
        locked_d   = locked_q;
        words_d    = words_q;

        case (state_q)
            SCAN_LDR_IDLE, SCAN_LDR_SHIFT, SCAN_LDR_ISSUE: begin
                if (scan_unlock) begin
                    // Unlock takes priority over both lockout and word completion.
                    state_d   = SCAN_LDR_DONE;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                end else if (state_q == SCAN_LDR_ISSUE && words_q == WORDS_MAX) begin
                    // Budget spent on the word just presented; no further attempts.
                    state_d   = SCAN_LDR_LOCKED;
                    locked_d  = 1'b1;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                end else if (key_sdi_valid) begin
                    if (word_done) begin
                        state_d    = SCAN_LDR_ISSUE;
                        scan_key_d = shift_word;
                        issued_d   = 1'b1;
                        words_d    = (words_q == WORDS_MAX) ? words_q : words_q + WCW'(1);
                        shreg_d    = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        state_d   = SCAN_LDR_SHIFT;
                        shreg_d   = shift_word;
                        bit_cnt_d = bit_cnt_inc;
                    end
                end else if (state_q == SCAN_LDR_SHIFT) begin
                    if (to_cnt_q == TO_LAST) begin
                        state_d   = SCAN_LDR_IDLE;
                        ferr_d    = 1'b1;
                        shreg_d   = '0;
                        bit_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TCW'(1);
                    end
                end else begin
                    state_d = SCAN_LDR_IDLE;
                end
            end

            SCAN_LDR_DONE: begin
                state_d = SCAN_LDR_DONE;
            end

            SCAN_LDR_LOCKED: begin
                state_d = SCAN_LDR_LOCKED;
            end

            default: begin
                state_d   = SCAN_LDR_IDLE;
                shreg_d   = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    assign scan_key        = scan_key_q;
    assign key_word_issued = issued_q;
    assign key_frame_err   = ferr_q;
    assign loader_locked   = locked_q;
    assign words_issued    = words_q;

endmodule

// File: tb/tb_vim_scan_key_loader.sv
module tb_vim_scan_key_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_sdi = 1'b0;
    logic        key_sdi_valid = 1'b0;
    logic        key_sof = 1'b0;
    logic        scan_unlock = 1'b0;
    logic [31:0] scan_key;
    logic        key_word_issued;
    logic        key_frame_err;
    logic        loader_locked;
    logic [4:0]  words_issued;

    int vectors = 0;
    int miscompares = 0;
    int issue_cnt = 0;
    int ferr_cnt = 0;
    int idle_viol = 0;
    logic [31:0] last_key = '0;
    logic [31:0] key_log [0:31];

    logic [31:0] unlock_words [0:7] = '{32'hEF012345, 32'h6789ABCD, 32'hEF012345, 32'h7891ABCD,
                                        32'h3D4E5F60, 32'hFF8A0B2C, 32'hFA1BC49D, 32'h87A5E932};

    vim_scan_key_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_sdi         (key_sdi),
        .key_sdi_valid   (key_sdi_valid),
        .key_sof         (key_sof),
        .scan_unlock     (scan_unlock),
        .scan_key        (scan_key),
        .key_word_issued (key_word_issued),
        .key_frame_err   (key_frame_err),
        .loader_locked   (loader_locked),
        .words_issued    (words_issued)
    );

    always #5 clk = ~clk;

    // Per-cycle observer: counts pulses and records presented words.
    always @(posedge clk) begin
        #2;
        if (key_word_issued) begin
            key_log[issue_cnt % 32] = scan_key;
            last_key = scan_key;
            issue_cnt++;
        end
        if (!key_word_issued && scan_key !== 32'h0) idle_viol++;
        if (key_frame_err) ferr_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        key_sdi_valid = 1'b0;
        key_sof = 1'b0;
        key_sdi = 1'b0;
        scan_unlock = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input logic sof_first);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            key_sdi = w[i];
            key_sdi_valid = 1'b1;
            key_sof = sof_first && (i == n - 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            key_sdi_valid = 1'b0;
            key_sof = 1'b0;
            key_sdi = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (scan_key !== 32'h0) begin
            miscompares++; $display("FAIL reset_scan_key got %h want 00000000", scan_key);
        end
        vectors++;
        if (key_word_issued !== 1'b0) begin
            miscompares++; $display("FAIL reset_issued got %b want 0", key_word_issued);
        end
        vectors++;
        if (key_frame_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_ferr got %b want 0", key_frame_err);
        end
        vectors++;
        if (loader_locked !== 1'b0) begin
            miscompares++; $display("FAIL reset_locked got %b want 0", loader_locked);
        end
        vectors++;
        if (words_issued !== 5'd0) begin
            miscompares++; $display("FAIL reset_words got %0d want 0", words_issued);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unlock_sequence();
        int base;
        do_reset();
        base = issue_cnt;
        for (int k = 0; k < 8; k++) send_bits(unlock_words[k], 32, 1'b0);
        idle(2);
        vectors++;
        if (issue_cnt - base !== 8) begin
            miscompares++; $display("FAIL seq_issue_count got %0d want 8", issue_cnt - base);
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (key_log[(base + k) % 32] !== unlock_words[k]) begin
                miscompares++;
                $display("FAIL seq_word%0d got %h want %h", k, key_log[(base + k) % 32], unlock_words[k]);
            end
        end
        vectors++;
        if (words_issued !== 5'd8) begin
            miscompares++; $display("FAIL seq_words got %0d want 8", words_issued);
        end
        // vim_scan_control accepts the sequence and raises unlock.
        @(negedge clk);
        scan_unlock = 1'b1;
        send_bits(32'hEF012345, 32, 1'b0);
        idle(2);
        vectors++;
        if (issue_cnt - base !== 8) begin
            miscompares++; $display("FAIL done_no_issue got %0d want 8", issue_cnt - base);
        end
        vectors++;
        if (words_issued !== 5'd8) begin
            miscompares++; $display("FAIL done_words_frozen got %0d want 8", words_issued);
        end
        scan_unlock = 1'b0;
    endtask

    task automatic test_timeout();
        int base;
        int fb;
        do_reset();
        fb = ferr_cnt;
        send_bits(32'h000ABCDE, 20, 1'b0);
        idle(1);
        repeat (63) @(negedge clk);
        vectors++;
        if (ferr_cnt !== fb) begin
            miscompares++; $display("FAIL timeout_early got %0d want %0d", ferr_cnt, fb);
        end
        @(negedge clk);
        vectors++;
        if (ferr_cnt !== fb + 1) begin
            miscompares++; $display("FAIL timeout_pulse got %0d want %0d", ferr_cnt, fb + 1);
        end
        base = issue_cnt;
        send_bits(32'hEF012345, 32, 1'b0);
        idle(2);
        vectors++;
        if (issue_cnt - base !== 1) begin
            miscompares++; $display("FAIL timeout_reissue_count got %0d want 1", issue_cnt - base);
        end
        vectors++;
        if (last_key !== 32'hEF012345) begin
            miscompares++; $display("FAIL timeout_reissue_key got %h want EF012345", last_key);
        end
        vectors++;
        if (ferr_cnt !== fb + 1) begin
            miscompares++; $display("FAIL timeout_single_pulse got %0d want %0d", ferr_cnt, fb + 1);
        end
    endtask

    task automatic test_sof();
        int base;
        int fb;
        do_reset();
        base = issue_cnt;
        fb = ferr_cnt;
        send_bits(32'h000002A5, 10, 1'b0);
        send_bits(32'hEF012345, 32, 1'b1);
        idle(2);
        vectors++;
        if (issue_cnt - base !== 1) begin
            miscompares++; $display("FAIL sof_issue_count got %0d want 1", issue_cnt - base);
        end
        vectors++;
        if (last_key !== 32'hEF012345) begin
            miscompares++; $display("FAIL sof_key got %h want EF012345", last_key);
        end
        vectors++;
        if (ferr_cnt !== fb) begin
            miscompares++; $display("FAIL sof_no_ferr got %0d want %0d", ferr_cnt, fb);
        end
    endtask

    task automatic test_lockout();
        int base;
        do_reset();
        base = issue_cnt;
        for (int k = 0; k < 15; k++) begin
            send_bits(32'h00000001, 32, 1'b0);
            idle(1);
        end
        idle(1);
        vectors++;
        if (words_issued !== 5'd15 || loader_locked !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_15 got words=%0d locked=%b want words=15 locked=0", words_issued, loader_locked);
        end
        send_bits(32'h00000001, 32, 1'b0);
        idle(1);
        vectors++;
        if (key_word_issued !== 1'b1 || loader_locked !== 1'b0 || words_issued !== 5'd16) begin
            miscompares++;
            $display("FAIL lock_16th_issue got issued=%b locked=%b words=%0d want 1 0 16",
                     key_word_issued, loader_locked, words_issued);
        end
        idle(1);
        vectors++;
        if (loader_locked !== 1'b1 || key_word_issued !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_rise got locked=%b issued=%b want 1 0", loader_locked, key_word_issued);
        end
        send_bits(32'h00000001, 32, 1'b0);
        idle(3);
        vectors++;
        if (issue_cnt - base !== 16) begin
            miscompares++; $display("FAIL lock_ignore got %0d want 16", issue_cnt - base);
        end
        vectors++;
        if (loader_locked !== 1'b1) begin
            miscompares++; $display("FAIL lock_sticky got %b want 1", loader_locked);
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if (loader_locked !== 1'b0 || words_issued !== 5'd0) begin
            miscompares++;
            $display("FAIL lock_clear got locked=%b words=%0d want 0 0", loader_locked, words_issued);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        send_bits(32'h11111111, 32, 1'b0);
        send_bits(32'h0000F0F0, 16, 1'b0);
        @(negedge clk);
        key_sdi = 1'b1;
        key_sdi_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (scan_key !== 32'h0 || key_word_issued !== 1'b0 || words_issued !== 5'd0 ||
            loader_locked !== 1'b0 || key_frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_word got key=%h issued=%b words=%0d want 0 0 0",
                     scan_key, key_word_issued, words_issued);
        end
        @(negedge clk);
        key_sdi_valid = 1'b0;
        rst_n = 1'b1;
        base = issue_cnt;
        send_bits(32'hEF012345, 32, 1'b0);
        idle(2);
        vectors++;
        if (issue_cnt - base !== 1 || last_key !== 32'hEF012345) begin
            miscompares++;
            $display("FAIL rst_mid_recover got count=%0d key=%h want 1 EF012345", issue_cnt - base, last_key);
        end
        send_bits(32'h6789ABCD, 32, 1'b0);
        idle(1);
        vectors++;
        if (key_word_issued !== 1'b1 || scan_key !== 32'h6789ABCD) begin
            miscompares++;
            $display("FAIL rst_issue_pre got issued=%b key=%h want 1 6789ABCD", key_word_issued, scan_key);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (scan_key !== 32'h0 || key_word_issued !== 1'b0 || words_issued !== 5'd0) begin
            miscompares++;
            $display("FAIL rst_issue got key=%h issued=%b words=%0d want 0 0 0",
                     scan_key, key_word_issued, words_issued);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(32'h3D4E5F60, 32, 1'b0);
        idle(2);
        vectors++;
        if (last_key !== 32'h3D4E5F60 || words_issued !== 5'd1) begin
            miscompares++;
            $display("FAIL rst_issue_recover got key=%h words=%0d want 3D4E5F60 1", last_key, words_issued);
        end
    endtask

    task automatic test_unlock_forced();
        int base;
        do_reset();
        base = issue_cnt;
        @(negedge clk);
        scan_unlock = 1'b1;
        send_bits(32'hFA1BC49D, 32, 1'b0);
        send_bits(32'h87A5E932, 32, 1'b0);
        idle(2);
        vectors++;
        if (issue_cnt - base !== 0) begin
            miscompares++; $display("FAIL forced_no_issue got %0d want 0", issue_cnt - base);
        end
        vectors++;
        if (scan_key !== 32'h0 || words_issued !== 5'd0) begin
            miscompares++;
            $display("FAIL forced_outputs got key=%h words=%0d want 0 0", scan_key, words_issued);
        end
        scan_unlock = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unlock_sequence();
        test_timeout();
        test_sof();
        test_lockout();
        test_reset_mid();
        test_unlock_forced();
        vectors++;
        if (idle_viol !== 0) begin
            miscompares++; $display("FAIL idle_word_nonzero got %0d cycles want 0", idle_viol);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
